// File: rtl/weight_loader.sv
// rtl/weight_loader.sv - streams weight words into kernel/bias/macc/scale regions of weight memory
module weight_loader #(
  parameter int DATA_W                = 32,
  parameter int ADDR_W                = 32,
  parameter int NUM_KERNEL            = 72,
  parameter int NUM_BIAS              = 4,
  parameter int NUM_MACC_COEFF        = 1,
  parameter int NUM_LAYER_SCALE       = 0,
  parameter int KERNEL_BASE_ADDR      = 0,
  parameter int BIAS_BASE_ADDR        = 72,
  parameter int MACC_COEFF_BASE_ADDR  = 76,
  parameter int LAYER_SCALE_BASE_ADDR = 77
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] weight_wr_data,
  output logic [ADDR_W-1:0] weight_wr_addr,
  output logic              weight_wr_en,
  output logic              busy,
  output logic              load_done,
  output logic              overflow_err,
  output logic [1:0]        section
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KERNEL = 3'd1,
    S_BIAS   = 3'd2,
    S_MACC   = 3'd3,
    S_SCALE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  function automatic int count_of(input int sec);
    case (sec)
      0:       count_of = NUM_KERNEL;
      1:       count_of = NUM_BIAS;
      2:       count_of = NUM_MACC_COEFF;
      default: count_of = NUM_LAYER_SCALE;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] sec);
    case (sec)
      2'd0:    base_of = ADDR_W'(KERNEL_BASE_ADDR);
      2'd1:    base_of = ADDR_W'(BIAS_BASE_ADDR);
      2'd2:    base_of = ADDR_W'(MACC_COEFF_BASE_ADDR);
      default: base_of = ADDR_W'(LAYER_SCALE_BASE_ADDR);
    endcase
  endfunction

  // First section at or after 'from' that holds any words; DONE when none remain.
  function automatic state_t seek(input int from);
    seek = S_DONE;
    for (int k = 3; k >= 0; k--) begin
      if (k >= from && count_of(k) != 0) seek = state_t'(3'(k + 1));
    end
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        section_q, section_d;
  logic              ovf_q, ovf_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

  logic              in_sec;
  logic              idle_or_done;
  logic [1:0]        cur_sec;
  logic [ADDR_W-1:0] last_idx;
  logic              accept;

  assign in_sec       = (state_q == S_KERNEL) || (state_q == S_BIAS) ||
                        (state_q == S_MACC)   || (state_q == S_SCALE);
  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign cur_sec      = 2'(state_q - 3'd1);
  assign last_idx     = ADDR_W'(count_of(int'(cur_sec)) - 1);
  assign accept       = s_valid && s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = seek(0);
      end
      S_KERNEL, S_BIAS, S_MACC, S_SCALE: begin
        if (accept && idx_q == last_idx) state_d = seek(int'(cur_sec) + 1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_ready   = in_sec || (state_q == S_DONE);
    busy      = in_sec;
    load_done = (state_q == S_DONE);
  end

  // Any state change is a section entry (or a restart), so the index rewinds.
  always_comb begin
    idx_d = idx_q;
    if (state_d != state_q) begin
      idx_d = '0;
    end else if (in_sec && accept) begin
      idx_d = idx_q + ADDR_W'(1);
    end

    section_d = section_q;
    if (state_d == S_KERNEL || state_d == S_BIAS || state_d == S_MACC || state_d == S_SCALE) begin
      section_d = 2'(state_d - 3'd1);
    end

    ovf_d = ovf_q;
    if (idle_or_done && start) begin
      ovf_d = 1'b0;
    end else if (state_q == S_DONE && s_valid) begin
      ovf_d = 1'b1;
    end

    wr_en_d   = in_sec && accept;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_addr_q;
    if (wr_en_d) begin
      wr_data_d = s_data;
      wr_addr_d = base_of(cur_sec) + idx_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      section_q <= 2'd0;
      ovf_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
    end else begin
      idx_q     <= idx_d;
      section_q <= section_d;
      ovf_q     <= ovf_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign weight_wr_en   = wr_en_q;
  assign weight_wr_data = wr_data_q;
  assign weight_wr_addr = wr_addr_q;
  assign overflow_err   = ovf_q;
  assign section        = section_q;

endmodule

// File: tb/tb_weight_loader.sv
// tb/tb_weight_loader.sv - directed bench for weight_loader (default, bias-skip and empty configs)
module tb_weight_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = 32'd0;

  logic        s_ready_a, wr_en_a, busy_a, load_done_a, overflow_a;
  logic [31:0] data_a, addr_a;
  logic [1:0]  section_a;
  logic        s_ready_b, wr_en_b, busy_b, load_done_b, overflow_b;
  logic [31:0] data_b, addr_b;
  logic [1:0]  section_b;
  logic        s_ready_c, wr_en_c, busy_c, load_done_c, overflow_c;
  logic [31:0] data_c, addr_c;
  logic [1:0]  section_c;

  weight_loader u_dut_a (
    .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_a),
    .weight_wr_data(data_a), .weight_wr_addr(addr_a), .weight_wr_en(wr_en_a), .busy(busy_a),
    .load_done(load_done_a), .overflow_err(overflow_a), .section(section_a)
  );

  weight_loader #(.NUM_BIAS(0), .NUM_LAYER_SCALE(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_b),
    .weight_wr_data(data_b), .weight_wr_addr(addr_b), .weight_wr_en(wr_en_b), .busy(busy_b),
    .load_done(load_done_b), .overflow_err(overflow_b), .section(section_b)
  );

  weight_loader #(.NUM_KERNEL(0), .NUM_BIAS(0), .NUM_MACC_COEFF(0), .NUM_LAYER_SCALE(0)) u_dut_c (
    .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_c),
    .weight_wr_data(data_c), .weight_wr_addr(addr_c), .weight_wr_en(wr_en_c), .busy(busy_c),
    .load_done(load_done_c), .overflow_err(overflow_c), .section(section_c)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          c_start = 0;
  int          done_cyc = -1;
  int          strobes_c = 0;
  logic        prev_valid = 1'b0;
  logic        ld_at_last = 1'b0;
  logic        busy_at_last = 1'b1;
  logic [63:0] qa[$];
  logic [63:0] qb[$];
  logic [1:0]  secq_b[$];
  logic [1:0]  last_sec_b = 2'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    prev_valid <= s_valid;
  end

  always @(negedge clk) begin
    if (wr_en_a) begin
      qa.push_back({addr_a, data_a});
      check("beat_before_strobe", 64'(prev_valid), 64'd1);
      if (addr_a == 32'd76) begin
        ld_at_last   = load_done_a;
        busy_at_last = busy_a;
      end
    end
    if (wr_en_b) qb.push_back({addr_b, data_b});
    if (wr_en_c) strobes_c++;
    if (section_b != last_sec_b) begin
      secq_b.push_back(section_b);
      last_sec_b = section_b;
    end
    if (load_done_a && done_cyc < 0) done_cyc = cyc;
  end

  // Called at posedge+1; returns at posedge+1 after the edge that sampled start.
  task automatic do_start();
    start   = 1'b1;
    c_start = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_words(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h100 + 32'(i);
      @(posedge clk); #1;
      if (gap) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic verify_a(input string tag);
    check({tag, "_count"}, 64'(qa.size()), 64'd77);
    for (int i = 0; i < qa.size(); i++)
      check(tag, qa[i], {32'(i), 32'h100 + 32'(i)});
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    check("rst_s_ready", 64'(s_ready_a), 64'd0);
    check("rst_wr_en", 64'(wr_en_a), 64'd0);
    check("rst_wr_data", 64'(data_a), 64'd0);
    check("rst_wr_addr", 64'(addr_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_load_done", 64'(load_done_a), 64'd0);
    check("rst_overflow", 64'(overflow_a), 64'd0);
    check("rst_section", 64'(section_a), 64'd0);
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(1);
    check("idle_s_ready", 64'(s_ready_a), 64'd0);

    // Back-to-back load on all three configurations at once.
    do_start();
    check("start_busy", 64'(busy_a), 64'd1);
    check("start_s_ready", 64'(s_ready_a), 64'd1);
    check("start_section", 64'(section_a), 64'd0);
    check("empty_done_1cyc", 64'(load_done_c), 64'd1);
    check("empty_busy", 64'(busy_c), 64'd0);
    send_words(77, 1'b0);
    idle_cycles(3);
    verify_a("b2b");
    check("b2b_latency", 64'(done_cyc - c_start), 64'd78);
    check("done_with_last_strobe", 64'(ld_at_last), 64'd1);
    check("busy_low_last_strobe", 64'(busy_at_last), 64'd0);
    check("b2b_overflow", 64'(overflow_a), 64'd0);
    check("b2b_load_done", 64'(load_done_a), 64'd1);
    check("section_hold", 64'(section_a), 64'd2);

    check("skip_count", 64'(qb.size()), 64'd75);
    for (int i = 0; i < qb.size(); i++)
      check("skip_write", qb[i], {(i < 72) ? 32'(i) : 32'(i + 4), 32'h100 + 32'(i)});
    check("skip_sec_changes", 64'(secq_b.size()), 64'd2);
    if (secq_b.size() == 2) begin
      check("skip_sec_first", 64'(secq_b[0]), 64'd2);
      check("skip_sec_second", 64'(secq_b[1]), 64'd3);
    end
    check("skip_overflow", 64'(overflow_b), 64'd1);
    check("empty_overflow", 64'(overflow_c), 64'd1);

    // One word past the end of the load.
    send_words(1, 1'b0);
    idle_cycles(2);
    check("extra_no_write", 64'(qa.size()), 64'd77);
    check("extra_overflow", 64'(overflow_a), 64'd1);

    // Restart with a colliding beat, then a gapped stream.
    qa.delete();
    start   = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hDEAD;
    @(posedge clk); #1;
    start   = 1'b0;
    s_valid = 1'b0;
    check("restart_ovf_clear", 64'(overflow_a), 64'd0);
    check("restart_done_clear", 64'(load_done_a), 64'd0);
    check("restart_busy", 64'(busy_a), 64'd1);
    send_words(77, 1'b1);
    idle_cycles(3);
    verify_a("gap");
    check("gap_load_done", 64'(load_done_a), 64'd1);
    check("gap_overflow", 64'(overflow_a), 64'd0);

    // Reset in the middle of a load, then a clean reload.
    qa.delete();
    do_start();
    send_words(40, 1'b0);
    check("midload_strobe", 64'(wr_en_a), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_wr_en", 64'(wr_en_a), 64'd0);
    check("mid_rst_addr", 64'(addr_a), 64'd0);
    check("mid_rst_data", 64'(data_a), 64'd0);
    check("mid_rst_busy", 64'(busy_a), 64'd0);
    check("mid_rst_s_ready", 64'(s_ready_a), 64'd0);
    check("mid_rst_section", 64'(section_a), 64'd0);
    check("mid_rst_load_done", 64'(load_done_a), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(1);
    qa.delete();
    do_start();
    send_words(77, 1'b0);
    idle_cycles(3);
    verify_a("after_rst");
    check("after_rst_done", 64'(load_done_a), 64'd1);

    check("empty_no_strobe", 64'(strobes_c), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
